// File: rtl/nes_pkg.sv
// nes_pkg: shared CPU-bus register addresses and OAM DMA state encoding
package nes_pkg;
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} oam_dma_state_t;
  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;
endpackage

// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU-side bus signals between the CPU core/wrapper (master) and the sprite DMA (slave)
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic        cpu_rdy;
  logic        bus_sel;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_wdata;
  logic [7:0]  bus_rdata;
  logic        dma_active;
  modport master (
    output cpu_addr, cpu_wdata, cpu_rw, bus_rdata,
    input  cpu_rdy, bus_sel, dma_addr, dma_rw, dma_wdata, dma_active
  );
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rw, bus_rdata,
    output cpu_rdy, bus_sel, dma_addr, dma_rw, dma_wdata, dma_active
  );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA copying CPU page $XX00-$XXFF into OAMDATA; OAM_DMA_ALIGN_EN adds odd-cycle ALIGN read
module oam_dma
  import nes_pkg::*;
(
  input logic      clk,
  input logic      n_reset,
  oam_dma_if.slave bus
);
  oam_dma_state_t r_state, w_next, w_halt_next;
  logic [7:0]     r_page, r_idx, r_data_q, w_page, w_idx;
  logic           w_trig;
  logic           r_cpu_rdy, r_bus_sel, r_dma_active, r_dma_rw;
  logic [15:0]    r_dma_addr;
`ifdef OAM_DMA_ALIGN_EN
  logic           r_cyc_odd;
  // free-running bus-cycle parity
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) r_cyc_odd <= 1'b0;
    else r_cyc_odd <= ~r_cyc_odd;
  // a halt cycle on an even cycle needs a dummy read so every READ lands even
  assign w_halt_next = r_cyc_odd ? READ : ALIGN;
`else
  assign w_halt_next = READ;
`endif
  // next state, trigger decode and datapath next values
  always_comb begin
    w_trig = !bus.cpu_rw && bus.cpu_addr == ADDR_OAMDMA;
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_trig ? HALT : IDLE;
      HALT:    w_next = bus.cpu_rw ? w_halt_next : HALT;
      ALIGN:   w_next = READ;
      READ:    w_next = WRITE;
      WRITE:   w_next = r_idx == 8'hFF ? IDLE : READ;
      default: w_next = IDLE;
    endcase
    w_page = (r_state == IDLE && w_trig) ? bus.cpu_wdata : r_page;
    w_idx  = (r_state == IDLE && w_trig) ? 8'h00 : r_state == WRITE ? r_idx + 8'd1 : r_idx;
  end
  // state, datapath and outputs registered from the next state
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      r_state      <= IDLE;
      r_page       <= 8'h00;
      r_idx        <= 8'h00;
      r_data_q     <= 8'h00;
      r_cpu_rdy    <= 1'b1;
      r_bus_sel    <= 1'b0;
      r_dma_active <= 1'b0;
      r_dma_rw     <= 1'b1;
      r_dma_addr   <= 16'h0000;
    end else begin
      r_state      <= w_next;
      r_page       <= w_page;
      r_idx        <= w_idx;
      r_data_q     <= r_state == READ ? bus.bus_rdata : r_data_q;
      r_cpu_rdy    <= w_next == IDLE;
      r_dma_active <= w_next != IDLE;
      r_bus_sel    <= w_next == ALIGN || w_next == READ || w_next == WRITE;
      r_dma_rw     <= w_next != WRITE;
      r_dma_addr   <= w_next == WRITE ? ADDR_OAMDATA :
                      (w_next == ALIGN || w_next == READ) ? {w_page, w_idx} : 16'h0000;
    end
  assign bus.cpu_rdy    = r_cpu_rdy;
  assign bus.bus_sel    = r_bus_sel;
  assign bus.dma_active = r_dma_active;
  assign bus.dma_rw     = r_dma_rw;
  assign bus.dma_addr   = r_dma_addr;
  assign bus.dma_wdata  = r_data_q;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed bench for oam_dma; memory returns addr[7:0]^8'h5A for every page
module tb_oam_dma;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic tb_odd;
  int   checks = 0;
  int   errors = 0;
`ifdef OAM_DMA_ALIGN_EN
  localparam int LEN_EVEN = 514;
`else
  localparam int LEN_EVEN = 513;
`endif
  oam_dma_if bus ();
  oam_dma dut (.clk(clk), .n_reset(n_reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.bus_rdata = bus.bus_sel ? (bus.dma_addr[7:0] ^ 8'h5A) : 8'h00;
  // reference bus-cycle parity: cleared by reset, toggles every edge
  always @(posedge clk or negedge n_reset)
    if (!n_reset) tb_odd <= 1'b0;
    else tb_odd <= ~tb_odd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_rdy"}, 32'(bus.cpu_rdy), 1);
    chk({tag, "_sel"}, 32'(bus.bus_sel), 0);
    chk({tag, "_act"}, 32'(bus.dma_active), 0);
  endtask

  task automatic reset_chk(input string tag);
    idle_chk(tag);
    chk({tag, "_addr"}, 32'(bus.dma_addr), 0);
    chk({tag, "_rw"}, 32'(bus.dma_rw), 1);
    chk({tag, "_wdata"}, 32'(bus.dma_wdata), 0);
  endtask

  // one $4014 transfer; halt cycle parity = want_odd; optional extra CPU writes, bus jamming, abort
  task automatic do_dma(input logic [7:0] pg, input int extra, input logic [15:0] xaddr,
                        input logic want_odd, input bit jam, input int abort_at, input int exp_len);
    int len = 0, nr = 0, nw = 0, bad_rd = 0, bad_wr = 0, bad_ctl = 0, bad_par = 0;
    bit done = 0;
    @(negedge clk);
    if (tb_odd !== (want_odd ^ extra[0] ^ 1'b1)) @(negedge clk);
    bus.cpu_rw = 1'b0; bus.cpu_addr = 16'h4014; bus.cpu_wdata = pg;
    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      chk("halt_w_rdy", 32'(bus.cpu_rdy), 0);
      chk("halt_w_sel", 32'(bus.bus_sel), 0);
      bus.cpu_rw = 1'b0; bus.cpu_addr = xaddr; bus.cpu_wdata = 8'h99;
    end
    @(negedge clk);
    chk("halt_rdy", 32'(bus.cpu_rdy), 0);
    chk("halt_sel", 32'(bus.bus_sel), 0);
    chk("halt_act", 32'(bus.dma_active), 1);
    bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h8000;
    len = 1;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      len++;
      if (bus.cpu_rdy !== 1'b0 || bus.dma_active !== 1'b1 || bus.bus_sel !== 1'b1) bad_ctl++;
      if (bus.dma_rw) begin
        if (bus.dma_addr !== {pg, nw[7:0]}) bad_rd++;
        nr++;
      end else begin
        if (bus.dma_addr !== 16'h2004 || bus.dma_wdata !== (nw[7:0] ^ 8'h5A)) bad_wr++;
`ifdef OAM_DMA_ALIGN_EN
        if (tb_odd !== 1'b1) bad_par++;
`endif
        if (nw == abort_at) begin
          n_reset = 1'b0;
          #1;
          reset_chk("abort");
          bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h8000;
          return;
        end
        nw++;
        done = (nw == 256);
      end
      if (done || !jam) begin
        bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h8000;
      end else begin
        bus.cpu_rw = 1'b0; bus.cpu_addr = 16'h4014; bus.cpu_wdata = ~pg;
      end
    end
    bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h8000;
    chk("timeout", 32'(done), 1);
    chk("len", len, exp_len);
    chk("reads", nr, exp_len - 257);
    chk("writes", nw, 256);
    chk("rd_addr_bad", bad_rd, 0);
    chk("wr_bad", bad_wr, 0);
    chk("ctl_bad", bad_ctl, 0);
`ifdef OAM_DMA_ALIGN_EN
    chk("wr_parity_bad", bad_par, 0);
`endif
    @(negedge clk);
    idle_chk("post");
    @(negedge clk);
    idle_chk("post2");
  endtask

  initial begin
    bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h8000; bus.cpu_wdata = 8'h00;
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    reset_chk("rst");
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    reset_chk("idle");
    do_dma(8'h02, 0, 16'h0000, 1'b1, 1'b0, -1, 513);
    do_dma(8'h02, 0, 16'h0000, 1'b0, 1'b0, -1, LEN_EVEN);
    do_dma(8'h07, 2, 16'h4014, 1'b1, 1'b0, -1, 513);
    do_dma(8'hFF, 0, 16'h0000, 1'b0, 1'b1, -1, LEN_EVEN);
    @(negedge clk);
    bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h4014;
    @(negedge clk);
    idle_chk("rd4014");
    bus.cpu_rw = 1'b0; bus.cpu_addr = 16'h4015; bus.cpu_wdata = 8'h05;
    @(negedge clk);
    idle_chk("wr4015");
    bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h8000;
    do_dma(8'h03, 0, 16'h0000, 1'b1, 1'b0, 128, 513);
    @(negedge clk);
    reset_chk("held");
    n_reset = 1'b1;
    do_dma(8'h04, 0, 16'h0000, 1'b1, 1'b0, -1, 513);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite DMA engine for the CPU-side bus. On a CPU write to $4014 it halts the CPU and copies 256 bytes from CPU page `$XX00–$XXFF` into PPU OAMDATA ($2004) as alternating read/write bus cycles. It sits between the CPU core and the CPU address decoder/PPU register port, and owns the bus while active. It runs in the CPU clock domain; one `clk` edge is one CPU bus cycle.

## Interface
- No parameters.
- `clk` in 1: CPU-cycle clock.
- `n_reset` in 1: asynchronous, active-low reset.
- `cpu_addr` in 16: CPU core address output.
- `cpu_wdata` in 8: CPU core write data.
- `cpu_rw` in 1: CPU core direction (1 = read, 0 = write).
- `cpu_rdy` out 1: CPU ready. Low requests the CPU to halt on its next read cycle.
- `bus_sel` out 1: 1 means the DMA drives the bus (address, data and rw mux select).
- `dma_addr` out 16: DMA bus address.
- `dma_rw` out 1: DMA bus direction.
- `dma_wdata` out 8: DMA write data.
- `bus_rdata` in 8: bus read data, valid at the end of a read cycle.
- `dma_active` out 1: transfer in progress, from HALT through the last WRITE.

## Operation
- **Trigger:** `cpu_rw`=0 and `cpu_addr`=16'h4014 on an edge while in IDLE.
  - Latch `page`=`cpu_wdata` and clear `idx`.
  - Go to HALT.
  - Triggers are ignored outside IDLE.
- **Parity:** internal bit `cyc_odd`. It resets to 0 and toggles on every `clk` edge, unconditionally.
- **States:** IDLE, HALT, ALIGN, READ, WRITE.
- **IDLE:** `cpu_rdy`=1, `bus_sel`=0.
- **HALT:** `cpu_rdy`=0, `bus_sel`=0. The CPU still owns the bus; writes cannot be halted.
  - Stay in HALT while `cpu_rw`=0.
  - When `cpu_rw`=1 is sampled, that cycle is the halt cycle. Next state is ALIGN if the next cycle is odd (`cyc_odd`=0 now), otherwise READ.
- **ALIGN:** `bus_sel`=1, `dma_rw`=1, `dma_addr`={`page`,`idx`}. This is a dummy read whose data is discarded. Go to READ.
- **READ:** `bus_sel`=1, `dma_rw`=1, `dma_addr`={`page`,`idx`}.
  - Capture `bus_rdata` into `data_q` at the edge.
  - Go to WRITE.
  - READ always occurs on an even cycle.
- **WRITE:** `bus_sel`=1, `dma_rw`=0, `dma_addr`=16'h2004, `dma_wdata`=`data_q`.
  - If `idx`=8'hFF, go to IDLE.
  - Otherwise `idx` increments and the next state is READ.
  - `idx` is 8-bit; the address never carries into `page`.
- `cpu_rdy`=0 in every non-IDLE state.
- `dma_active`=1 in every non-IDLE state.
- **Reset mid-transfer:** immediate return to IDLE. No partial-state resume.

## Timing
- **Reset values:**
  - `cpu_rdy`=1, `bus_sel`=0, `dma_active`=0
  - `dma_addr`=16'h0000, `dma_rw`=1, `dma_wdata`=8'h00
  - `page`=0, `idx`=0, `cyc_odd`=0, state IDLE
- All outputs are registered or decoded from registered state only. There is no combinational path from `cpu_*` to any output.
- `cpu_rdy` falls on the edge that samples the $4014 write.
- **Transfer length from the halt cycle to the last WRITE, inclusive:**
  - 513 cycles when aligned.
  - 514 cycles with ALIGN.
  - Plus one HALT cycle per extra CPU write cycle (for example, back-to-back writes delay the halt).
- `cpu_rdy` returns high on the edge that leaves the final WRITE. The CPU resumes on the following cycle.
- **Byte order:** `$XX00` first and `$XXFF` last. Exactly 256 writes to $2004.

## Configuration
- **`OAM_DMA_ALIGN_EN` defined:** parity tracking and the ALIGN state are compiled in, giving 513/514-cycle behaviour as specified above.
- **Not defined:**
  - `cyc_odd` and ALIGN are removed.
  - HALT goes straight to READ.
  - Transfer is always 513 cycles.
  - READ/WRITE may land on either parity.

## Structure
- Shared package `nes_pkg` holds:
  - `oam_dma_state_t` enum (IDLE, HALT, ALIGN, READ, WRITE)
  - `ADDR_OAMDMA`=16'h4014
  - `ADDR_OAMDATA`=16'h2004
- No sub-module. A single FSM with the `idx`/`page`/`data_q` datapath is sufficient.
- The bus mux is driven by `bus_sel` in the CPU wrapper, not in this block.

## Test plan
- Write $02 to $4014 with the halt cycle at `cyc_odd`=1. Memory $0200–$02FF holds the pattern i^8'h5A.
  - Required: 513 cycles.
  - 256 writes to $2004 with data 8'h5A, 8'h5B, … in order.
  - `cpu_rdy` is high afterwards.
- Same stimulus with the halt cycle at `cyc_odd`=0.
  - Required: one ALIGN read of $0200, then 514 cycles total.
  - Without `OAM_DMA_ALIGN_EN`: 513 cycles.
- $4014 write followed by 2 more CPU write cycles.
  - Required: HALT persists 3 cycles.
  - First READ of $0700 occurs only after the first `cpu_rw`=1.
- Page $FF.
  - Required: reads $FF00–$FFFF, no carry past $FFFF.
  - Last write data is taken from $FFFF.
- Assert `n_reset` low at `idx`=8'h80 during WRITE.
  - Required: outputs go to reset values immediately, `cpu_rdy`=1.
  - A new $4014 write restarts from `idx`=0.
- Negative triggers: a CPU read of $4014, a write to $4015, and a $4014 write issued while a transfer is active.
  - Required: no new transfer.
  - `page` is unchanged mid-transfer.
